ram16x8_bist: RTL and testbench



---
 rtl/ram16x8_bist.sv | 175 +++++++++++++++++
 tb/tb_ram16x8_bist.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x8_bist.sv
// rtl/ram16x8_bist.sv - two-pass pattern BIST initiator for a 16x8 synchronous RAM
// Writes SEED^{a,a} then reads and compares, then repeats with the inverted pattern.
module ram16x8_bist #(
  parameter logic [7:0] SEED   = 8'h55,
  parameter int         RD_LAT = 1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] wr_data,
  output logic [3:0] w_addr,
  output logic       wen,
  output logic [3:0] r_addr,
  output logic       ren,
  input  logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [3:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, W0, R0, D0, W1, R1, D1, FIN} state_t;
  localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  wr_data_q;
  logic [3:0]  w_addr_q;
  logic        wen_q;
  logic [3:0]  r_addr_q;
  logic        ren_q;
  logic [7:0]  rexp_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [5:0]  err_cnt_q;
  logic [3:0]  first_err_q;

  logic [RD_LAT-1:0] vld_q;
  logic [7:0]        exp_q [RD_LAT];
  logic [3:0]        adr_q [RD_LAT];

  logic              mism;
  logic [5:0]        err_cnt_d;
  logic [3:0]        first_err_d;

  function automatic logic [7:0] pat(input logic [3:0] a, input logic inv);
    return (SEED ^ {a, a}) ^ {8{inv}};
  endfunction

  // Tagged expected data emerges from the last stage on the edge dout is valid.
  always_comb begin
    mism        = vld_q[RD_LAT-1] && (dout != exp_q[RD_LAT-1]);
    err_cnt_d   = err_cnt_q + {5'd0, mism};
    first_err_d = (mism && err_cnt_q == 6'd0) ? adr_q[RD_LAT-1] : first_err_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i] <= '0;
        adr_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= ren_q;
      exp_q[0] <= rexp_q;
      adr_q[0] <= r_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_data_q   <= '0;
      w_addr_q    <= '0;
      wen_q       <= 1'b0;
      r_addr_q    <= '0;
      ren_q       <= 1'b0;
      rexp_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      done_q      <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      case (state_q)
        IDLE: if (start) begin
          state_q     <= W0;
          busy_q      <= 1'b1;
          pass_q      <= 1'b0;
          err_cnt_q   <= '0;
          first_err_q <= '0;
          cnt_q       <= '0;
          wen_q       <= 1'b1;
          w_addr_q    <= '0;
          wr_data_q   <= pat(4'd0, 1'b0);
        end
        W0, W1: begin
          if (cnt_q == 4'd15) begin
            state_q  <= (state_q == W0) ? R0 : R1;
            cnt_q    <= '0;
            ren_q    <= 1'b1;
            r_addr_q <= '0;
            rexp_q   <= pat(4'd0, state_q == W1);
          end else begin
            cnt_q     <= cnt_q + 4'd1;
            wen_q     <= 1'b1;
            w_addr_q  <= cnt_q + 4'd1;
            wr_data_q <= pat(cnt_q + 4'd1, state_q == W1);
          end
        end
        R0, R1: begin
          if (cnt_q == 4'd15) begin
            state_q <= (state_q == R0) ? D0 : D1;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_q + 4'd1;
            ren_q    <= 1'b1;
            r_addr_q <= cnt_q + 4'd1;
            rexp_q   <= pat(cnt_q + 4'd1, state_q == R1);
          end
        end
        D0: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q   <= W1;
            cnt_q     <= '0;
            wen_q     <= 1'b1;
            w_addr_q  <= '0;
            wr_data_q <= pat(4'd0, 1'b1);
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        D1: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= FIN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 6'd0);
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_data        = wr_data_q;
  assign w_addr         = w_addr_q;
  assign wen            = wen_q;
  assign r_addr         = r_addr_q;
  assign ren            = ren_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ram16x8_bist.sv
// tb/tb_ram16x8_bist.sv - directed bench for ram16x8_bist at RD_LAT 1 and 3
// Each DUT drives its own behavioural RAM; fault mode 1 sticks bit 3 of addr 9 low, 2 forces dout to zero.
module tb_ram16x8_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start3;
  logic [7:0] wr_data1, wr_data3, dout1, dout3;
  logic [3:0] w_addr1, w_addr3, r_addr1, r_addr3, first1, first3;
  logic wen1, wen3, ren1, ren3, busy1, busy3, done1, done3, pass1, pass3;
  logic [5:0] err1, err3;

  int fault = 0;
  int cur = 1;
  int checks = 0;
  int errors = 0;

  ram16x8_bist #(.SEED(8'h55), .RD_LAT(1)) dut1 (
    .clock(clk), .rst_n(rst_n), .start(start1),
    .wr_data(wr_data1), .w_addr(w_addr1), .wen(wen1),
    .r_addr(r_addr1), .ren(ren1), .dout(dout1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_addr(first1)
  );

  ram16x8_bist #(.SEED(8'h55), .RD_LAT(3)) dut3 (
    .clock(clk), .rst_n(rst_n), .start(start3),
    .wr_data(wr_data3), .w_addr(w_addr3), .wen(wen3),
    .r_addr(r_addr3), .ren(ren3), .dout(dout3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_err_addr(first3)
  );

  logic [7:0] mem1 [16];
  logic [7:0] mem3 [16];
  logic [7:0] p1, p3a, p3b, p3c;

  function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [3:0] a);
    if (fault == 1 && a == 4'd9) return d & 8'hF7;
    return d;
  endfunction

  always @(posedge clk) begin
    if (wen1) mem1[w_addr1] <= wr_data1;
    if (ren1) p1 <= rd_fault(mem1[r_addr1], r_addr1);
    if (wen3) mem3[w_addr3] <= wr_data3;
    p3a <= ren3 ? rd_fault(mem3[r_addr3], r_addr3) : 8'h00;
    p3b <= p3a;
    p3c <= p3b;
  end

  assign dout1 = (fault == 2) ? 8'h00 : p1;
  assign dout3 = (fault == 2) ? 8'h00 : p3c;

  logic s_wen, s_ren, s_busy, s_done, s_pass;
  logic [5:0] s_err;
  logic [3:0] s_first, s_waddr, s_raddr;
  logic [7:0] s_wdata;

  always_comb begin
    if (cur == 3) begin
      s_wen = wen3; s_ren = ren3; s_busy = busy3; s_done = done3; s_pass = pass3;
      s_err = err3; s_first = first3; s_waddr = w_addr3; s_raddr = r_addr3; s_wdata = wr_data3;
    end else begin
      s_wen = wen1; s_ren = ren1; s_busy = busy1; s_done = done1; s_pass = pass1;
      s_err = err1; s_first = first1; s_waddr = w_addr1; s_raddr = r_addr1; s_wdata = wr_data1;
    end
  end

  logic mon_clr = 1'b1;
  int n_wen, n_ren, n_both, n9;
  logic [7:0] cap0, cap1;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_wen <= 0; n_ren <= 0; n_both <= 0; n9 <= 0; cap0 <= 8'h00; cap1 <= 8'h00;
    end else begin
      if (s_wen) n_wen <= n_wen + 1;
      if (s_ren) n_ren <= n_ren + 1;
      if (s_wen && s_ren) n_both <= n_both + 1;
      if (s_wen && s_waddr == 4'd9) begin
        if (n9 == 0) cap0 <= s_wdata;
        else cap1 <= s_wdata;
        n9 <= n9 + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wen"}, s_wen, 0);
    check({tag, " ren"}, s_ren, 0);
    check({tag, " busy"}, s_busy, 0);
    check({tag, " done"}, s_done, 0);
    check({tag, " pass"}, s_pass, 0);
    check({tag, " err_cnt"}, s_err, 0);
    check({tag, " first_err_addr"}, s_first, 0);
    check({tag, " w_addr"}, s_waddr, 0);
    check({tag, " r_addr"}, s_raddr, 0);
    check({tag, " wr_data"}, s_wdata, 0);
  endtask

  // Pulses start, returns the number of edges after the accepting edge until done is seen.
  task automatic do_run(input int sel, output int cyc);
    cur = sel;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    check("busy after start", s_busy, 1);
    check("err_cnt cleared at start", s_err, 0);
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (s_done) begin
        cyc = c;
        break;
      end
    end
    check("done seen within budget", cyc >= 0, 1);
  endtask

  typedef struct {
    int sel;
    int fault;
    int cyc;
    int err;
    int first;
    int pass;
  } vec_t;

  vec_t vecs [6];
  int cyc, ndone, dcyc;

  initial begin
    vecs[0] = '{1, 0, 66, 0, 0, 1};
    vecs[1] = '{1, 1, 66, 1, 9, 0};
    vecs[2] = '{1, 2, 66, 30, 0, 0};
    vecs[3] = '{3, 0, 70, 0, 0, 1};
    vecs[4] = '{3, 1, 70, 1, 9, 0};
    vecs[5] = '{3, 2, 70, 30, 0, 0};

    rst_n = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur = 1; #1; check_all_zero("reset dut1");
    cur = 3; #1; check_all_zero("reset dut3");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      fault = vecs[i].fault;
      do_run(vecs[i].sel, cyc);
      check($sformatf("v%0d done cycle", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d busy at done", i), s_busy, 0);
      check($sformatf("v%0d err_cnt", i), s_err, vecs[i].err);
      check($sformatf("v%0d first_err_addr", i), s_first, vecs[i].first);
      check($sformatf("v%0d pass", i), s_pass, vecs[i].pass);
      @(posedge clk); #1;
      check($sformatf("v%0d done one cycle", i), s_done, 0);
      check($sformatf("v%0d pass held", i), s_pass, vecs[i].pass);
      check($sformatf("v%0d wen cycles", i), n_wen, 32);
      check($sformatf("v%0d ren cycles", i), n_ren, 32);
      check($sformatf("v%0d wen ren overlap", i), n_both, 0);
      check($sformatf("v%0d addr9 data pass0", i), cap0, 8'hCC);
      check($sformatf("v%0d addr9 data pass1", i), cap1, 8'h33);
    end

    // Restarts mid-run are ignored; start during done is ignored, the next cycle is accepted.
    cur = 1;
    fault = 2;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    ndone = 0;
    dcyc = -1;
    for (int c = 1; c <= 66; c++) begin
      start1 = (c == 10 || c == 40);
      @(posedge clk); #1;
      if (s_done) begin
        ndone++;
        dcyc = c;
      end
    end
    start1 = 1'b0;
    check("restart done count", ndone, 1);
    check("restart done cycle", dcyc, 66);
    start1 = 1'b1;
    @(posedge clk); #1;
    check("start in FIN ignored busy", s_busy, 0);
    check("start in FIN ignored err_cnt", s_err, 30);
    fault = 0;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("start after FIN busy", s_busy, 1);
    check("start after FIN err_cnt cleared", s_err, 0);
    dcyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (s_done) begin
        dcyc = c;
        break;
      end
    end
    check("back to back done cycle", dcyc, 66);
    check("back to back pass", s_pass, 1);

    // Asynchronous reset in the middle of R0 aborts the run.
    fault = 0;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ren high mid R0", s_ren, 1);
    check("r_addr mid R0", s_raddr, 4);
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (s_done) ndone++;
    end
    check("no done after abort", ndone, 0);
    do_run(1, cyc);
    check("post reset done cycle", cyc, 66);
    check("post reset pass", s_pass, 1);
    check("post reset err_cnt", s_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
